// File: rtl/tdm_pkg.sv
// Shared constants and state encoding for the TDM receiver.
//   N_CH  : time slots per frame
//   SEL_W : slot index width
//   state_t : HUNT (searching for frame marker) / RECV (frame aligned)
package tdm_pkg;
  localparam int N_CH  = 8;
  localparam int SEL_W = $clog2(N_CH);

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } state_t;
endpackage

// File: rtl/tdm_rx_dec.sv
// Enabled binary-to-one-hot decoder (3-to-8 at default sizing).
//   en     : in  1      decode enable; all outputs low when 0
//   sel    : in  SEL_W  binary index
//   onehot : out N_OUT  onehot[i] = en && sel == i
module tdm_rx_dec #(
  parameter int SEL_W = 3,
  parameter int N_OUT = 8
) (
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  output logic [N_OUT-1:0] onehot
);
  for (genvar i = 0; i < N_OUT; i++) begin : g_dec
    assign onehot[i] = en && (sel == SEL_W'(i));
  end
endmodule

// File: rtl/tdm_rx.sv
// Serial TDM frame receiver. Aligns on a slot-0 frame marker, gathers one
// bit per strobe into a shadow register and publishes the whole frame on
// data_out when the last slot arrives. Framing errors drop back to HUNT or
// restart the frame.
//   clk, rst_n : clock, async active-low reset
//   en         : in  slot strobe (one bit consumed per en=1 cycle)
//   data_in    : in  serial bit for the current slot
//   sync_in    : in  frame marker, legal only in slot 0
//   data_out   : out last complete frame, bit i = slot i
//   valid      : out one-cycle pulse, data_out just updated
//   slot       : out next slot to capture (0 while hunting)
//   err        : out one-cycle pulse on missing or early sync
module tdm_rx
  import tdm_pkg::*;
#(
  parameter int N_CH  = tdm_pkg::N_CH,
  parameter int SEL_W = tdm_pkg::SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             data_in,
  input  logic             sync_in,
  output logic [N_CH-1:0]  data_out,
  output logic             valid,
  output logic [SEL_W-1:0] slot,
  output logic             err
);
  state_t            state, state_n;
  logic [SEL_W-1:0]  slot_n;
  // Last slot goes straight to data_out, so the shadow omits it.
  logic [N_CH-2:0]   shadow, shadow_n;
  logic [N_CH-1:0]   dout_n;
  logic              valid_n, err_n;
  logic [N_CH-1:0]   dec;
  logic              start;

  // Strobed slot decode: dec[0] flags a slot-0 strobe, dec[N_CH-1] the
  // frame-closing strobe, the middle bits are shadow write enables.
  tdm_rx_dec #(.SEL_W(SEL_W), .N_OUT(N_CH)) u_dec (
    .en     (en),
    .sel    (slot),
    .onehot (dec)
  );

  always_comb begin
    state_n  = state;
    slot_n   = slot;
    shadow_n = shadow;
    dout_n   = data_out;
    valid_n  = 1'b0;
    err_n    = 1'b0;
    start    = 1'b0;
    if (en) begin
      unique case (state)
        HUNT: start = sync_in;
        RECV: begin
          if (sync_in) begin
            // Sync anywhere but slot 0 is early: flag it, then realign.
            start = 1'b1;
            err_n = !dec[0];
          end else if (dec[0]) begin
            err_n   = 1'b1;
            state_n = HUNT;
            slot_n  = '0;
          end else if (dec[N_CH-1]) begin
            dout_n  = {data_in, shadow};
            valid_n = 1'b1;
            slot_n  = '0;
          end else begin
            for (int i = 1; i < N_CH-1; i++)
              if (dec[i]) shadow_n[i] = data_in;
            slot_n = slot + SEL_W'(1);
          end
        end
        default: state_n = HUNT;
      endcase
      if (start) begin
        shadow_n[0] = data_in;
        slot_n      = SEL_W'(1);
        state_n     = RECV;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HUNT;
      slot     <= '0;
      shadow   <= '0;
      data_out <= '0;
      valid    <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      slot     <= slot_n;
      shadow   <= shadow_n;
      data_out <= dout_n;
      valid    <= valid_n;
      err      <= err_n;
    end
  end
endmodule

// File: tb/tb_tdm_rx.sv
module tb_tdm_rx;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, data_in, sync_in;
  logic [7:0] data_out;
  logic       valid, err;
  logic [2:0] slot;
  int         n_cmp = 0, n_bad = 0;

  tdm_rx #(.N_CH(8), .SEL_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .data_in(data_in), .sync_in(sync_in),
    .data_out(data_out), .valid(valid), .slot(slot), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One en=1 cycle; outputs sampled 1 time unit after the capturing edge.
  task automatic strobe(input logic d, input logic s);
    @(negedge clk);
    en = 1'b1; data_in = d; sync_in = s;
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  // Idle cycle with garbage on data/sync that must be ignored.
  task automatic idle();
    @(negedge clk);
    en = 1'b0; data_in = 1'b1; sync_in = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic frame(input string tag, input logic [7:0] v, input logic gap);
    for (int i = 0; i < 8; i++) begin
      strobe(v[i], i == 0);
      if (i < 7) begin
        chk({tag, " valid-mid"}, 16'(valid), 16'h0);
        if (gap) begin
          idle();
          chk({tag, " valid-gap"}, 16'(valid), 16'h0);
        end
      end
    end
    chk({tag, " valid"}, 16'(valid), 16'h1);
    chk({tag, " err"},   16'(err),   16'h0);
    chk({tag, " data"},  16'(data_out), 16'(v));
    chk({tag, " slot"},  16'(slot),  16'h0);
    idle();
    chk({tag, " valid-pulse"}, 16'(valid), 16'h0);
    chk({tag, " data-hold"},   16'(data_out), 16'(v));
  endtask

  initial begin
    en = 1'b0; data_in = 1'b0; sync_in = 1'b0; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst data",  16'(data_out), 16'h0);
    chk("rst valid", 16'(valid), 16'h0);
    chk("rst err",   16'(err),   16'h0);
    chk("rst slot",  16'(slot),  16'h0);
    @(negedge clk); rst_n = 1'b1;

    // Back-to-back frames
    frame("f1", 8'hA5, 1'b0);
    frame("f2", 8'h3C, 1'b0);
    // Strobes separated by idle cycles
    frame("gap", 8'hA5, 1'b1);

    // Missing sync at slot 0 after a complete frame
    strobe(1'b1, 1'b0);
    chk("miss err",   16'(err), 16'h1);
    chk("miss valid", 16'(valid), 16'h0);
    chk("miss slot",  16'(slot), 16'h0);
    chk("miss data",  16'(data_out), 16'hA5);
    // Still hunting: unsynced strobes discarded quietly
    for (int i = 0; i < 3; i++) begin
      strobe(1'b1, 1'b0);
      chk("hunt err",  16'(err), 16'h0);
      chk("hunt vld",  16'(valid), 16'h0);
      chk("hunt slot", 16'(slot), 16'h0);
    end
    chk("hunt data", 16'(data_out), 16'hA5);
    frame("f3", 8'h3C, 1'b0);

    // Early sync at slot 4
    frame("f4", 8'hA5, 1'b0);
    for (int i = 0; i < 4; i++) strobe(1'b0, i == 0);
    chk("pre-early slot", 16'(slot), 16'h4);
    strobe(1'b1, 1'b1);
    chk("early err",   16'(err), 16'h1);
    chk("early valid", 16'(valid), 16'h0);
    chk("early slot",  16'(slot), 16'h1);
    chk("early data",  16'(data_out), 16'hA5);
    for (int i = 1; i < 7; i++) begin
      strobe(1'b1, 1'b0);
      chk("early hold", 16'(data_out), 16'hA5);
      chk("early err0", 16'(err), 16'h0);
    end
    strobe(1'b1, 1'b0);
    chk("early fvalid", 16'(valid), 16'h1);
    chk("early fdata",  16'(data_out), 16'hFF);

    // Reset mid-frame during slot 5
    for (int i = 0; i < 5; i++) strobe(1'b1, i == 0);
    chk("pre-rst slot", 16'(slot), 16'h5);
    @(negedge clk); en = 1'b1; data_in = 1'b1; sync_in = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("arst data",  16'(data_out), 16'h0);
    chk("arst slot",  16'(slot), 16'h0);
    chk("arst valid", 16'(valid), 16'h0);
    chk("arst err",   16'(err), 16'h0);
    en = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    strobe(1'b1, 1'b0);
    chk("post-rst hunt slot", 16'(slot), 16'h0);
    chk("post-rst hunt err",  16'(err), 16'h0);
    frame("f81", 8'h81, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/tdm_rx.md
TDM_RX -- requirements
Module: tdm_rx

Interface
REQ-001 SHALL have parameter N_CH, default 8, number of time slots (channels) per frame.
REQ-002 SHALL have parameter SEL_W, default 3, slot index width, equal to clog2(N_CH).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  slot strobe; one serial bit is consumed per clk cycle in which en=1.
REQ-006 SHALL have port data_in  input  1  serial TDM bit for the current slot.
REQ-007 SHALL have port sync_in  input  1  frame marker; qualified by en, valid only in slot 0.
REQ-008 SHALL have port data_out  output  N_CH  last complete frame; bit i = slot i.
REQ-009 SHALL have port valid  output  1  one-cycle pulse: data_out just updated.
REQ-010 SHALL have port slot  output  SEL_W  index of the next slot to be captured.
REQ-011 SHALL have port err  output  1  one-cycle pulse on a framing error.

Function
REQ-012 SHALL implement two states: HUNT (no frame alignment) and RECV (aligned).
REQ-013 Cycles with en=0 SHALL change no state, and data_in and sync_in SHALL be ignored in them.
REQ-014 In HUNT, en=1 with sync_in=0 SHALL be discarded, with no err.
REQ-015 In HUNT, en=1 with sync_in=1 SHALL write data_in to shadow bit 0, set slot=1, and enter RECV.
REQ-016 In RECV, en=1 with sync_in=0 and slot in 1..N_CH-2 SHALL write data_in to shadow[slot] and increment slot.
REQ-017 In RECV, en=1 at slot=N_CH-1 with sync_in=0 SHALL load data_out with the shadow bits plus data_in as the MSB, wrap slot to 0, and stay in RECV.
REQ-018 In that same edge, valid SHALL be set so that it is high for exactly the following cycle (latency 1 from the last strobe).
REQ-019 In RECV, en=1 at slot=0 with sync_in=1 SHALL start a new frame exactly as in REQ-015.
REQ-020 In RECV, en=1 at slot=0 with sync_in=0 (missing sync) SHALL pulse err, discard the bit, and return to HUNT with slot=0.
REQ-021 In RECV, en=1 with sync_in=1 at slot≠0 (early sync) SHALL pulse err, drop the partial frame, and restart per REQ-015 with no valid.
REQ-022 data_out SHALL change only on the REQ-017 edge and SHALL hold between frames, including across HUNT.
REQ-023 A partial frame SHALL never reach data_out.
REQ-024 err and valid SHALL never be high in the same cycle.
REQ-025 slot SHALL read 0 whenever the block is in HUNT.

Reset
REQ-026 Asserting rst_n=0 SHALL, asynchronously, force state=HUNT, slot=0, shadow=0, data_out=0, valid=0, and err=0.
REQ-027 Reset mid-frame SHALL discard the partial frame.
REQ-028 The first strobe after rst_n rises SHALL be evaluated per the HUNT rules.

Structure
REQ-029 A shared package tdm_pkg SHALL hold N_CH, SEL_W, and the state enum {HUNT, RECV}.
REQ-030 Shadow write enables SHALL be produced by one instance of the existing 3-to-8 decoder block driven by slot and gated with en.
REQ-031 No other sub-module SHALL be used.

Verification
REQ-032 Reset, then frames with sync on slot 0 and bits 1,0,1,0,0,1,0,1 (slot 0 first) -> data_out=8'hA5 with a single valid pulse 1 cycle after the 8th strobe; a second frame of 8'h3C follows.
REQ-033 Same frame with en toggling 1,0,1,0,... -> data_out=8'hA5, and valid only after the 8th en=1 cycle.
REQ-034 Strobes with sync_in=0 while in HUNT -> no valid, no err, slot=0; a later sync -> normal capture.
REQ-035 After frame 8'hA5, sync_in=1 at slot 4 -> err pulse, the new frame is 8'hFF captured from that strobe, and data_out stays 8'hA5 until the new frame completes.
REQ-036 After a complete frame, sync_in=0 at slot 0 -> err pulse, state HUNT, and data_out held.
REQ-037 rst_n low during slot 5 -> all outputs 0 immediately; after release, a full frame 8'h81 -> data_out=8'h81.
